gfx_readback_dma: RTL

- Reverse-direction DMA: copies a rectangle of pixels from VRAM into an 8 KB window of CPU RAM, for sprite-background save/restore and screen capture.
- Sits beside the VRAM-write DMA on the same CPU register bus and the same VGA free-bus arbitration.
- Programmed through 8 write-only registers, then reads VRAM and writes CPU RAM autonomously.

---
 rtl/gfx_readback_dma.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gfx_readback_dma.sv
// Readback DMA: copies a VRAM rectangle into an 8 KB CPU RAM page.
// Each VRAM pixel read in cycle N becomes a one-cycle CPU RAM write strobe in cycle N+1.
module gfx_readback_dma #(
    parameter logic CLR_ON_DONE = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_cpu_ce_b,
    input  logic        i_cpu_we_b,
    input  logic [2:0]  i_cpu_addr,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_free_vbus_b,
    output logic [15:0] o_vram_addr,
    output logic        o_vram_re_b,
    input  logic [7:0]  i_vram_data,
    output logic [12:0] o_ram_addr,
    output logic [1:0]  o_ram_page,
    output logic [7:0]  o_ram_data,
    output logic        o_ram_we_b,
    output logic        o_bus_oe,
    output logic        o_active,
    output logic        o_done,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  src_x_q, src_x_d;
    logic [7:0]  src_y_q, src_y_d;
    logic [7:0]  dst_col_q, dst_col_d;
    logic [4:0]  dst_row_q, dst_row_d;
    logic [1:0]  dst_page_q, dst_page_d;
    logic [7:0]  width_q, width_d;
    logic [4:0]  height_q, height_d;
    logic [7:0]  key_q, key_d;
    logic        skip_en_q, skip_en_d;
    logic [7:0]  x_cnt_q, x_cnt_d;
    logic [4:0]  y_cnt_q, y_cnt_d;
    logic [7:0]  data_hold_q, data_hold_d;
    logic [12:0] addr_hold_q, addr_hold_d;
    logic [1:0]  page_hold_q, page_hold_d;
    logic        wr_pend_q, wr_pend_d;
    logic        done_q, done_d;

    logic        cpu_wr;
    logic [7:0]  vram_x, vram_y, ram_col;
    logic [4:0]  ram_row;

    // Bus handshake: i_free_vbus_b low grants the VRAM bus for this cycle only; a read
    // issued then returns data by the next rising edge. RAM writes are posted, no back-pressure.
    assign cpu_wr  = !i_cpu_ce_b && !i_cpu_we_b && (state_q == ST_IDLE);
    assign vram_x  = src_x_q + x_cnt_q;
    assign vram_y  = src_y_q + y_cnt_q;
    assign ram_col = dst_col_q + x_cnt_q;
    assign ram_row = dst_row_q + y_cnt_q;

    always_comb begin
        state_d     = state_q;
        src_x_d     = src_x_q;
        src_y_d     = src_y_q;
        dst_col_d   = dst_col_q;
        dst_row_d   = dst_row_q;
        dst_page_d  = dst_page_q;
        width_d     = width_q;
        height_d    = height_q;
        key_d       = key_q;
        skip_en_d   = skip_en_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        data_hold_d = data_hold_q;
        addr_hold_d = addr_hold_q;
        page_hold_d = page_hold_q;
        wr_pend_d   = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_wr) begin
                    case (i_cpu_addr)
                        3'd0: src_x_d   = i_cpu_data;
                        3'd1: src_y_d   = i_cpu_data;
                        3'd2: dst_col_d = i_cpu_data;
                        3'd3: begin
                            dst_row_d  = i_cpu_data[4:0];
                            dst_page_d = i_cpu_data[6:5];
                        end
                        3'd4: width_d   = i_cpu_data;
                        3'd5: height_d  = i_cpu_data[4:0];
                        3'd6: key_d     = i_cpu_data;
                        default: begin
                            skip_en_d = i_cpu_data[0];
                            x_cnt_d   = 8'd0;
                            y_cnt_d   = 5'd0;
                            state_d   = ST_SETTLE;
                        end
                    endcase
                end
            end
            ST_SETTLE: state_d = ST_RUN;
            ST_RUN: begin
                // A busy bus cycle is a pure stall: counters and holds keep their values.
                if (!i_free_vbus_b) begin
                    data_hold_d = i_vram_data;
                    addr_hold_d = {ram_row, ram_col};
                    page_hold_d = dst_page_q;
                    wr_pend_d   = !(skip_en_q && (i_vram_data == key_q));
                    if (x_cnt_q == width_q) begin
                        x_cnt_d = 8'd0;
                        if (y_cnt_q == height_q) begin
                            state_d = ST_FLUSH;
                        end else begin
                            y_cnt_d = y_cnt_q + 5'd1;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (CLR_ON_DONE) begin
                    width_d  = 8'd0;
                    height_d = 5'd0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q     <= ST_IDLE;
            src_x_q     <= 8'd0;
            src_y_q     <= 8'd0;
            dst_col_q   <= 8'd0;
            dst_row_q   <= 5'd0;
            dst_page_q  <= 2'd0;
            width_q     <= 8'd0;
            height_q    <= 5'd0;
            key_q       <= 8'd0;
            skip_en_q   <= 1'b0;
            x_cnt_q     <= 8'd0;
            y_cnt_q     <= 5'd0;
            data_hold_q <= 8'd0;
            addr_hold_q <= 13'd0;
            page_hold_q <= 2'd0;
            wr_pend_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            dst_col_q   <= dst_col_d;
            dst_row_q   <= dst_row_d;
            dst_page_q  <= dst_page_d;
            width_q     <= width_d;
            height_q    <= height_d;
            key_q       <= key_d;
            skip_en_q   <= skip_en_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            data_hold_q <= data_hold_d;
            addr_hold_q <= addr_hold_d;
            page_hold_q <= page_hold_d;
            wr_pend_q   <= wr_pend_d;
            done_q      <= done_d;
        end
    end

    assign o_vram_re_b = (state_q == ST_RUN) ? i_free_vbus_b : 1'b1;
    assign o_vram_addr = (state_q == ST_RUN) ? {vram_y, vram_x} : 16'd0;
    assign o_ram_addr  = addr_hold_q;
    assign o_ram_page  = page_hold_q;
    assign o_ram_data  = data_hold_q;
    assign o_ram_we_b  = ~wr_pend_q;
    assign o_bus_oe    = (state_q != ST_IDLE);
    assign o_active    = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_dbg_state = state_q;

endmodule
